// File: rtl/image_fader.sv
// Full-screen palettised image renderer with a frame-synchronous fade-in / hold / fade-out sequencer.
// Scales an IMG_W x IMG_H ROM image to the raster; RGB lags DrawX/DrawY by exactly three cycles.
module image_fader #(
   parameter int IMG_W           = 300,
   parameter int IMG_H           = 300,
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int ADDR_W          = 17,
   parameter int IDX_W           = 5,
   parameter int FRAMES_PER_STEP = 2,
   parameter int HOLD_FRAMES     = 120
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

   localparam logic [15:0] STEP_LAST    = 16'(FRAMES_PER_STEP - 1);
   localparam logic [15:0] HOLD_LAST    = 16'(HOLD_FRAMES - 1);
   localparam bit          HOLD_FOREVER = (HOLD_FRAMES == 0);

   function automatic logic [3:0] fade(input logic [3:0] c, input logic [4:0] lvl);
      logic [7:0] prod;
      prod = 8'(c) * 8'(lvl);
      return 4'(prod >> 4);
   endfunction

   function automatic logic [4:0] sat_inc(input logic [4:0] l);
      return (l >= 5'd16) ? 5'd16 : l + 5'd1;
   endfunction

   function automatic logic [4:0] sat_dec(input logic [4:0] l);
      return (l == 5'd0) ? 5'd0 : l - 5'd1;
   endfunction

   state_t      state;
   logic [4:0]  level;
   logic [15:0] step_cnt;
   logic [15:0] hold_cnt;
   logic        origin_q;
   logic        at_origin;
   logic        tick;
   logic        vld_p0, vld_p1;
   logic        in_view;
   logic [31:0] x_w, y_w, col, row, addr_full;

   // 32-bit products leave ample headroom for DrawX*IMG_W at any legal raster size.
   always_comb begin
      x_w       = 32'(DrawX);
      y_w       = 32'(DrawY);
      in_view   = (x_w < 32'(SCREEN_W)) && (y_w < 32'(SCREEN_H));
      col       = (x_w * 32'(IMG_W)) / 32'(SCREEN_W);
      row       = (y_w * 32'(IMG_H)) / 32'(SCREEN_H);
      addr_full = row * 32'(IMG_W) + col;
   end

   assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign tick      = at_origin && !origin_q;
   assign pal_index = rom_q;

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         rom_address <= '0;
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         red         <= 4'd0;
         green       <= 4'd0;
         blue        <= 4'd0;
      end else begin
         // stage p0: ROM address
         rom_address <= in_view ? ADDR_W'(addr_full) : '0;
         vld_p0      <= blank;
         // stage p1: ROM read in flight, palette looks up rom_q combinationally
         vld_p1      <= vld_p0;
         // stage p2: faded colour
         red         <= vld_p1 ? fade(pal_red,   level) : 4'd0;
         green       <= vld_p1 ? fade(pal_green, level) : 4'd0;
         blue        <= vld_p1 ? fade(pal_blue,  level) : 4'd0;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state    <= IDLE;
         level    <= 5'd0;
         step_cnt <= 16'd0;
         hold_cnt <= 16'd0;
         origin_q <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= 1'b0;
         origin_q <= at_origin;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FADE_IN;
                  step_cnt <= 16'd0;
                  busy     <= 1'b1;
               end
            end
            FADE_IN: begin
               if (abort) begin
                  state    <= FADE_OUT;
                  step_cnt <= 16'd0;
               end else if (tick) begin
                  if (step_cnt == STEP_LAST) begin
                     step_cnt <= 16'd0;
                     level    <= sat_inc(level);
                     if (level >= 5'd15) begin
                        state    <= HOLD;
                        hold_cnt <= 16'd0;
                     end
                  end else begin
                     step_cnt <= step_cnt + 16'd1;
                  end
               end
            end
            HOLD: begin
               if (abort) begin
                  state    <= FADE_OUT;
                  step_cnt <= 16'd0;
               end else if (tick && !HOLD_FOREVER) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state    <= FADE_OUT;
                     step_cnt <= 16'd0;
                  end else begin
                     hold_cnt <= hold_cnt + 16'd1;
                  end
               end
            end
            FADE_OUT: begin
               // An abort before the first step leaves level at 0; the next step still ends the run.
               if (tick) begin
                  if (step_cnt == STEP_LAST) begin
                     step_cnt <= 16'd0;
                     level    <= sat_dec(level);
                     if (level <= 5'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     step_cnt <= step_cnt + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/image_fader.md
Name: image_fader

Overview:
- Parametrised full-screen image renderer for title, game-over and "done" screens.
- Scales an IMG_W x IMG_H palettised ROM image to the full SCREEN_W x SCREEN_H raster.
- Pipelines address, ROM and palette stages, and delays blank to match them.
- Adds a frame-synchronous fade-in / hold / fade-out sequencer with start, abort and done handshakes. Sits between the VGA controller and the colour mapper.

Parameters:
- IMG_W, 300, source image width in pixels (1..SCREEN_W)
- IMG_H, 300, source image height in pixels (1..SCREEN_H)
- SCREEN_W, 640, visible raster width
- SCREEN_H, 480, visible raster height
- ADDR_W, 17, ROM address width (2^ADDR_W >= IMG_W*IMG_H)
- IDX_W, 5, palette index width
- FRAMES_PER_STEP, 2, frame ticks per fade level step (>=1)
- HOLD_FRAMES, 120, frame ticks spent at full brightness; 0 = hold until abort

Ports:
- vga_clk  in  1  pixel clock; DrawX advances one per cycle
- Reset  in  1  synchronous active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = visible region
- start  in  1  one-cycle pulse; begins a sequence when idle
- abort  in  1  one-cycle pulse; forces fade-out
- rom_address  out  ADDR_W  image ROM address (ROM has 1-cycle registered read)
- rom_q  in  IDX_W  ROM data
- pal_index  out  IDX_W  index to combinational palette
- pal_red, pal_green, pal_blue  in  4 each  palette colour
- red, green, blue  out  4 each  faded output colour
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset clears all of the following, and takes priority over every other input:
  - red, green, blue, rom_address and the pipeline registers to 0
  - busy and done to 0
  - state to IDLE, level to 0, all counters to 0
- Address mapping:
  - col = floor(DrawX*IMG_W/SCREEN_W); row = floor(DrawY*IMG_H/SCREEN_H)
  - rom_address = row*IMG_W + col, registered (cycle 1)
  - When DrawX >= SCREEN_W or DrawY >= SCREEN_H, rom_address = 0
  - Intermediate products must be wide enough not to overflow, e.g. 639*300 needs 18 bits.
- Pipeline: rom_q is valid at cycle 2; pal_index = rom_q; RGB is registered at cycle 3. Total latency from DrawX/DrawY to RGB is exactly 3 cycles. blank is delayed 3 cycles alongside the data.
- Output colour: channel = (pal_channel * level) >> 4, with level in 0..16. Level 16 passes the palette value exactly. Output is 0 whenever the delayed blank is 0.
- Frame tick: a one-cycle pulse the first cycle (DrawX,DrawY) == (0,0), i.e. the previous cycle was not (0,0). level and the state machine change only on a frame tick, except start, abort and Reset.
- States:
  - IDLE: level = 0, busy = 0. A start pulse moves to FADE_IN on the next cycle.
  - FADE_IN: every FRAMES_PER_STEP ticks, level += 1. When level reaches 16, go to HOLD and clear the hold counter.
  - HOLD: level = 16.
    - HOLD_FRAMES > 0: count ticks; after HOLD_FRAMES ticks go to FADE_OUT.
    - HOLD_FRAMES = 0: stay until abort.
  - FADE_OUT: every FRAMES_PER_STEP ticks, level -= 1. When level reaches 0, go to IDLE and pulse done for 1 cycle.
- Abort in FADE_IN or HOLD: go to FADE_OUT the next cycle, keeping the current level. The step counter clears.
- Abort in FADE_OUT or IDLE: ignored.
- Start outside IDLE: ignored.
- Start and abort together in IDLE: start wins, abort is ignored.
- Level saturates at 0..16 and never wraps.
- Image rendering continues in every state; only brightness is gated.

Test Plan:
- Reset held 2 cycles mid-FADE_IN at level 7 -> next cycle level=0, state IDLE, RGB=0, busy=0, done=0.
- Mapping: DrawX=639, DrawY=479 -> rom_address=299*300+299=89999 three cycles before RGB. DrawX=320, DrawY=0 -> 150. DrawX=700 -> 0.
- Latency: HOLD state, blank=1, pal_red=0xF at the cycle rom_q is consumed -> red=0xF exactly 3 cycles after DrawX presented. blank=0 -> red=0 with the same 3-cycle alignment.
- Full sequence (FRAMES_PER_STEP=1, HOLD_FRAMES=2), start pulse:
  - level 1..16 on successive frame ticks
  - 2 ticks in HOLD
  - level 15..0
  - done pulses once when level reaches 0
  - busy high from cycle after start until IDLE
- Fade arithmetic: pal_green=0xA at level 8 -> green=0x5; level 16 -> 0xA; level 1 -> 0x0.
- Abort at level 5 in FADE_IN -> FADE_OUT next cycle, level 4,3,2,1,0 on next ticks, one done pulse. Start during FADE_OUT ignored. Start+abort together in IDLE -> FADE_IN.
